// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared widths, meta field offsets and dispatch FSM types
package lb_pkg;
    localparam int HTTP_DATA_WIDTH      = 512;
    localparam int HTTP_KEEP_WIDTH      = HTTP_DATA_WIDTH / 8;
    localparam int HTTP_META_WIDTH      = 98;
    localparam int HTTP_META_META_WIDTH = 48;
    localparam int HTTP_METHOD_WIDTH    = 32;
    localparam int OPERATOR_ID_WIDTH    = 16;
    localparam int N_REGIONS            = 4;
    localparam int MAX_OUTSTANDING      = 8;
    localparam int REGION_WIDTH         = $clog2(N_REGIONS) + 1;
    localparam int REGION_IDX_WIDTH     = $clog2(N_REGIONS);

    localparam int META_HAS_HDR_BIT = 80;
    localparam int META_HAS_BDY_BIT = 81;
    localparam int META_OID_LSB     = 82;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_META,
        ST_HDR,
        ST_BDY,
        ST_DRAIN_HDR,
        ST_DRAIN_BDY
    } dispatch_state_t;

    typedef struct packed {
        logic                         has_body;
        logic                         has_headers;
        logic [OPERATOR_ID_WIDTH-1:0] oid;
    } meta_flags_t;

    function automatic meta_flags_t meta_flags(input logic [HTTP_META_WIDTH-1:0] meta);
        meta_flags_t f;
        f.has_body    = meta[META_HAS_BDY_BIT];
        f.has_headers = meta[META_HAS_HDR_BIT];
        f.oid         = meta[META_OID_LSB +: OPERATOR_ID_WIDTH];
        return f;
    endfunction
endpackage

// File: rtl/region_credit_counter.sv
// rtl/region_credit_counter.sv - per-region outstanding request counter
module region_credit_counter
    import lb_pkg::*;
#(
    parameter int COUNT_WIDTH = OPERATOR_ID_WIDTH,
    parameter int LIMIT       = MAX_OUTSTANDING
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   inc,
    input  logic                   dec,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   below_limit
);
    // A completion arriving with nothing outstanding is ignored rather than wrapping
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + COUNT_WIDTH'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - COUNT_WIDTH'(1);
        end
    end

    assign below_limit = count < COUNT_WIDTH'(LIMIT);
endmodule

// File: rtl/region_dispatcher.sv
// rtl/region_dispatcher.sv - forwards routed requests (meta, header, body) to a region
module region_dispatcher
    import lb_pkg::*;
(
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic                                       route_valid,
    output logic                                       route_ready,
    input  logic [REGION_WIDTH-1:0]                    route_region,
    input  logic [HTTP_META_WIDTH-1:0]                 route_meta,
    input  logic [HTTP_DATA_WIDTH-1:0]                 hdr_tdata,
    input  logic [HTTP_KEEP_WIDTH-1:0]                 hdr_tkeep,
    input  logic                                       hdr_tlast,
    input  logic                                       hdr_tvalid,
    output logic                                       hdr_tready,
    input  logic [HTTP_DATA_WIDTH-1:0]                 bdy_tdata,
    input  logic [HTTP_KEEP_WIDTH-1:0]                 bdy_tkeep,
    input  logic                                       bdy_tlast,
    input  logic                                       bdy_tvalid,
    output logic                                       bdy_tready,
    output logic [N_REGIONS-1:0]                       reg_meta_valid,
    input  logic [N_REGIONS-1:0]                       reg_meta_ready,
    output logic [HTTP_META_WIDTH-1:0]                 reg_meta_data,
    output logic [N_REGIONS-1:0]                       reg_data_valid,
    input  logic [N_REGIONS-1:0]                       reg_data_ready,
    output logic [HTTP_DATA_WIDTH-1:0]                 reg_data_tdata,
    output logic [HTTP_KEEP_WIDTH-1:0]                 reg_data_tkeep,
    output logic                                       reg_data_tlast,
    input  logic [N_REGIONS-1:0]                       reg_done,
    input  logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0]     region_oid_in,
    output logic [N_REGIONS*2*OPERATOR_ID_WIDTH-1:0]   region_stats_out,
    output logic [31:0]                                drop_cnt
);
    dispatch_state_t               state, state_next;
    logic [REGION_IDX_WIDTH-1:0]   cur_idx;
    logic [HTTP_META_WIDTH-1:0]    cur_meta;
    logic                          cur_has_hdr, cur_has_bdy;
    logic [N_REGIONS-1:0]          cur_onehot, below_limit, credit_inc;
    logic [OPERATOR_ID_WIDTH-1:0]  outstanding [N_REGIONS];
    logic                          route_in_range, route_fire, meta_fire;
    meta_flags_t                   route_flags;
    logic [OPERATOR_ID_WIDTH-1:0]  unused_route_oid;

    assign route_in_range   = route_region < REGION_WIDTH'(N_REGIONS);
    assign route_flags      = meta_flags(route_meta);
    assign unused_route_oid = route_flags.oid;
    assign route_fire       = route_valid && route_ready;
    assign cur_onehot       = N_REGIONS'(1) << cur_idx;
    assign meta_fire        = (state == ST_META) && reg_meta_ready[cur_idx];
    assign credit_inc       = meta_fire ? cur_onehot : '0;

    for (genvar i = 0; i < N_REGIONS; i++) begin : g_credit
        region_credit_counter u_credit (
            .aclk        (aclk),
            .aresetn     (aresetn),
            .inc         (credit_inc[i]),
            .dec         (reg_done[i]),
            .count       (outstanding[i]),
            .below_limit (below_limit[i])
        );
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_idx     <= '0;
            cur_meta    <= '0;
            cur_has_hdr <= 1'b0;
            cur_has_bdy <= 1'b0;
            drop_cnt    <= '0;
        end else if (route_fire) begin
            cur_idx     <= route_region[REGION_IDX_WIDTH-1:0];
            cur_meta    <= route_meta;
            cur_has_hdr <= route_flags.has_headers;
            cur_has_bdy <= route_flags.has_body;
            if (!route_in_range) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    // Unreset on purpose: the oid fields must track region_oid_in even while in reset
    always_ff @(posedge aclk) begin
        for (int i = 0; i < N_REGIONS; i++) begin
            region_stats_out[i*2*OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH] <= outstanding[i];
            region_stats_out[i*2*OPERATOR_ID_WIDTH+OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH] <=
                region_oid_in[i*OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH];
        end
    end

    always_comb begin
        state_next     = state;
        route_ready    = 1'b0;
        hdr_tready     = 1'b0;
        bdy_tready     = 1'b0;
        reg_meta_valid = '0;
        reg_data_valid = '0;
        case (state)
            ST_IDLE: begin
                route_ready = aresetn &&
                              (!route_in_range || below_limit[route_region[REGION_IDX_WIDTH-1:0]]);
                if (route_valid && route_ready) begin
                    if (route_in_range)               state_next = ST_META;
                    else if (route_flags.has_headers) state_next = ST_DRAIN_HDR;
                    else if (route_flags.has_body)    state_next = ST_DRAIN_BDY;
                end
            end
            ST_META: begin
                reg_meta_valid = cur_onehot;
                if (reg_meta_ready[cur_idx]) begin
                    state_next = cur_has_hdr ? ST_HDR : (cur_has_bdy ? ST_BDY : ST_IDLE);
                end
            end
            ST_HDR: begin
                reg_data_valid = hdr_tvalid ? cur_onehot : '0;
                hdr_tready     = reg_data_ready[cur_idx];
                if (hdr_tvalid && hdr_tready && hdr_tlast) begin
                    state_next = cur_has_bdy ? ST_BDY : ST_IDLE;
                end
            end
            ST_BDY: begin
                reg_data_valid = bdy_tvalid ? cur_onehot : '0;
                bdy_tready     = reg_data_ready[cur_idx];
                if (bdy_tvalid && bdy_tready && bdy_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN_HDR: begin
                hdr_tready = 1'b1;
                if (hdr_tvalid && hdr_tlast) begin
                    state_next = cur_has_bdy ? ST_DRAIN_BDY : ST_IDLE;
                end
            end
            ST_DRAIN_BDY: begin
                bdy_tready = 1'b1;
                if (bdy_tvalid && bdy_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign reg_meta_data  = cur_meta;
    assign reg_data_tdata = (state == ST_BDY) ? bdy_tdata : hdr_tdata;
    assign reg_data_tkeep = (state == ST_BDY) ? bdy_tkeep : hdr_tkeep;
    assign reg_data_tlast = (state == ST_BDY) ? bdy_tlast : hdr_tlast;
endmodule

// File: tb/tb_region_dispatcher.sv
// tb/tb_region_dispatcher.sv - directed self-checking bench for region_dispatcher
module tb_region_dispatcher;
    logic         aclk;
    logic         aresetn;
    logic         route_valid;
    logic         route_ready;
    logic [2:0]   route_region;
    logic [97:0]  route_meta;
    logic [511:0] hdr_tdata, bdy_tdata, reg_data_tdata;
    logic [63:0]  hdr_tkeep, bdy_tkeep, reg_data_tkeep;
    logic         hdr_tlast, hdr_tvalid, hdr_tready;
    logic         bdy_tlast, bdy_tvalid, bdy_tready;
    logic [3:0]   reg_meta_valid, reg_meta_ready, reg_data_valid, reg_data_ready, reg_done;
    logic [97:0]  reg_meta_data;
    logic         reg_data_tlast;
    logic [63:0]  region_oid_in;
    logic [127:0] region_stats_out;
    logic [31:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0]  OIDS = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    localparam logic [127:0] STATS_RESET = {16'hD003, 16'h0, 16'hC002, 16'h0,
                                            16'hB001, 16'h0, 16'hA000, 16'h0};

    region_dispatcher dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .route_valid      (route_valid),
        .route_ready      (route_ready),
        .route_region     (route_region),
        .route_meta       (route_meta),
        .hdr_tdata        (hdr_tdata),
        .hdr_tkeep        (hdr_tkeep),
        .hdr_tlast        (hdr_tlast),
        .hdr_tvalid       (hdr_tvalid),
        .hdr_tready       (hdr_tready),
        .bdy_tdata        (bdy_tdata),
        .bdy_tkeep        (bdy_tkeep),
        .bdy_tlast        (bdy_tlast),
        .bdy_tvalid       (bdy_tvalid),
        .bdy_tready       (bdy_tready),
        .reg_meta_valid   (reg_meta_valid),
        .reg_meta_ready   (reg_meta_ready),
        .reg_meta_data    (reg_meta_data),
        .reg_data_valid   (reg_data_valid),
        .reg_data_ready   (reg_data_ready),
        .reg_data_tdata   (reg_data_tdata),
        .reg_data_tkeep   (reg_data_tkeep),
        .reg_data_tlast   (reg_data_tlast),
        .reg_done         (reg_done),
        .region_oid_in    (region_oid_in),
        .region_stats_out (region_stats_out),
        .drop_cnt         (drop_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [97:0] mk_meta(input logic [15:0] oid, input bit hb, input bit hh,
                                            input logic [47:0] tag);
        return {oid, hb, hh, 32'h4745_5420, tag};
    endfunction

    function automatic logic [15:0] stat_cnt(input int i);
        return region_stats_out[i*32 +: 16];
    endfunction

    task automatic route(input logic [2:0] r, input logic [97:0] m);
        int n;
        n = 0;
        @(negedge aclk);
        route_valid  = 1'b1;
        route_region = r;
        route_meta   = m;
        #1;
        while (!route_ready && n < 50) begin
            @(negedge aclk);
            #1;
            n++;
        end
        check("route_accept", route_ready, 1'b1);
        @(negedge aclk);
        route_valid = 1'b0;
        #1;
    endtask

    task automatic beat(input bit is_bdy, input logic [63:0] d, input bit last,
                        input logic [3:0] exp_valid);
        @(negedge aclk);
        hdr_tvalid = !is_bdy;
        bdy_tvalid = is_bdy;
        hdr_tdata  = {448'h0, is_bdy ? ~d : d};
        bdy_tdata  = {448'h0, is_bdy ? d : ~d};
        hdr_tlast  = is_bdy ? !last : last;
        bdy_tlast  = is_bdy ? last : !last;
        #1;
        check("data_valid", reg_data_valid, exp_valid);
        if (exp_valid != 4'b0000) begin
            check("data_tdata", reg_data_tdata[63:0], d);
            check("data_tlast", reg_data_tlast, last);
        end
        check("src_ready", is_bdy ? bdy_tready : hdr_tready, 1'b1);
        check("other_ready", is_bdy ? hdr_tready : bdy_tready, 1'b0);
        check("meta_valid_quiet", reg_meta_valid, 4'b0000);
    endtask

    task automatic idle_streams();
        @(negedge aclk);
        hdr_tvalid = 1'b0;
        bdy_tvalid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [97:0] m;
        aresetn        = 1'b0;
        route_valid    = 1'b0;
        route_region   = 3'd0;
        route_meta     = '0;
        hdr_tdata      = '0;
        hdr_tkeep      = '1;
        hdr_tlast      = 1'b0;
        hdr_tvalid     = 1'b0;
        bdy_tdata      = '0;
        bdy_tkeep      = '1;
        bdy_tlast      = 1'b0;
        bdy_tvalid     = 1'b0;
        reg_meta_ready = 4'hF;
        reg_data_ready = 4'hF;
        reg_done       = 4'h0;
        region_oid_in  = OIDS;

        repeat (3) @(negedge aclk);
        #1;
        check("rst_route_ready", route_ready, 1'b0);
        check("rst_hdr_ready", hdr_tready, 1'b0);
        check("rst_bdy_ready", bdy_tready, 1'b0);
        check("rst_meta_valid", reg_meta_valid, 4'b0000);
        check("rst_data_valid", reg_data_valid, 4'b0000);
        check("rst_drop_cnt", drop_cnt, 32'd0);
        check("rst_stats", region_stats_out, STATS_RESET);
        @(negedge aclk);
        aresetn = 1'b1;

        // region 2, three header beats then two body beats
        m = mk_meta(16'hB001, 1'b1, 1'b1, 48'h0000_0000_0A01);
        route(3'd2, m);
        check("t1_meta_valid", reg_meta_valid, 4'b0100);
        check("t1_meta_data", reg_meta_data, m);
        beat(1'b0, 64'h1111, 1'b0, 4'b0100);
        beat(1'b0, 64'h2222, 1'b0, 4'b0100);
        beat(1'b0, 64'h3333, 1'b1, 4'b0100);
        beat(1'b1, 64'h4444, 1'b0, 4'b0100);
        beat(1'b1, 64'h5555, 1'b1, 4'b0100);
        idle_streams();
        check("t1_idle_ready", route_ready, 1'b1);
        check("t1_outstanding2", stat_cnt(2), 16'd1);
        check("t1_oid2", region_stats_out[2*32+16 +: 16], 16'hC002);

        // region 1, meta only, meta ready held low for four cycles
        reg_meta_ready = 4'b1101;
        m = mk_meta(16'hA000, 1'b0, 1'b0, 48'h0000_0000_0B02);
        route(3'd1, m);
        for (int i = 0; i < 4; i++) begin
            check("t2_meta_hold", reg_meta_valid, 4'b0010);
            check("t2_meta_data", reg_meta_data, m);
            check("t2_busy", route_ready, 1'b0);
            @(negedge aclk);
            #1;
        end
        reg_meta_ready = 4'hF;
        #1;
        check("t2_meta_last", reg_meta_valid, 4'b0010);
        @(negedge aclk);
        #1;
        check("t2_meta_gone", reg_meta_valid, 4'b0000);
        check("t2_next_ready", route_ready, 1'b1);
        @(negedge aclk);
        @(negedge aclk);
        #1;
        check("t2_outstanding1", stat_cnt(1), 16'd1);

        // region 0 filled to the limit, then one credit returned
        for (int i = 0; i < 8; i++) begin
            route(3'd0, mk_meta(16'h0, 1'b0, 1'b0, 48'(i)));
        end
        @(negedge aclk);
        route_valid  = 1'b1;
        route_region = 3'd0;
        route_meta   = mk_meta(16'h0, 1'b0, 1'b0, 48'h99);
        #1;
        check("t3_block", route_ready, 1'b0);
        @(negedge aclk);
        #1;
        check("t3_block2", route_ready, 1'b0);
        check("t3_outstanding8", stat_cnt(0), 16'd8);
        reg_done = 4'b0001;
        @(negedge aclk);
        reg_done = 4'b0000;
        #1;
        check("t3_unblock", route_ready, 1'b1);
        @(negedge aclk);
        route_valid = 1'b0;
        #1;
        check("t3_outstanding7", stat_cnt(0), 16'd7);
        check("t3_meta_valid", reg_meta_valid, 4'b0001);
        @(negedge aclk);
        @(negedge aclk);
        #1;
        check("t3_outstanding8b", stat_cnt(0), 16'd8);

        // out-of-range region with a two-beat body is dropped
        route(3'd5, mk_meta(16'h0, 1'b1, 1'b0, 48'h0C05));
        check("t4_drop_cnt", drop_cnt, 32'd1);
        check("t4_no_meta", reg_meta_valid, 4'b0000);
        beat(1'b1, 64'h6666, 1'b0, 4'b0000);
        beat(1'b1, 64'h7777, 1'b1, 4'b0000);
        idle_streams();
        route_region = 3'd3;
        #1;
        check("t4_idle_ready", route_ready, 1'b1);

        // completion on an empty region, then simultaneous inc/dec on region 3
        @(negedge aclk);
        reg_done = 4'b1000;
        @(negedge aclk);
        reg_done = 4'b0000;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        check("t5_sat_zero", stat_cnt(3), 16'd0);
        route(3'd3, mk_meta(16'h0, 1'b0, 1'b0, 48'h31));
        route(3'd3, mk_meta(16'h0, 1'b0, 1'b0, 48'h32));
        repeat (3) @(negedge aclk);
        #1;
        check("t5_outstanding2", stat_cnt(3), 16'd2);
        route(3'd3, mk_meta(16'h0, 1'b0, 1'b0, 48'h33));
        check("t5_meta_valid", reg_meta_valid, 4'b1000);
        reg_done = 4'b1000;
        @(negedge aclk);
        reg_done = 4'b0000;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        check("t5_inc_dec", stat_cnt(3), 16'd2);

        // reset in the middle of a body
        route(3'd2, mk_meta(16'h0, 1'b1, 1'b0, 48'h0D06));
        beat(1'b1, 64'h8888, 1'b0, 4'b0100);
        @(negedge aclk);
        #1;
        check("t6_pre_valid", reg_data_valid, 4'b0100);
        #1;
        aresetn = 1'b0;
        #1;
        check("t6_async_data_valid", reg_data_valid, 4'b0000);
        check("t6_async_bdy_ready", bdy_tready, 1'b0);
        check("t6_async_route_ready", route_ready, 1'b0);
        check("t6_async_meta_valid", reg_meta_valid, 4'b0000);
        bdy_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        check("t6_stats_cleared", region_stats_out, STATS_RESET);
        check("t6_drop_cleared", drop_cnt, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        m = mk_meta(16'hB001, 1'b0, 1'b1, 48'h0E07);
        route(3'd1, m);
        check("t6_meta_valid", reg_meta_valid, 4'b0010);
        check("t6_meta_data", reg_meta_data, m);
        beat(1'b0, 64'h9999, 1'b1, 4'b0010);
        idle_streams();
        @(negedge aclk);
        #1;
        check("t6_outstanding1", stat_cnt(1), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
